// File: rtl/io_post_ctl_pkg.sv
// Shared definitions for the IO posted-write controller: buffer depth,
// non-posted FSM encodings and the buffer occupancy step helper.
package io_post_ctl_pkg;

  localparam logic [1:0] PW_DEPTH = 2'd2;

  typedef enum logic [1:0] {
    NP_IDLE  = 2'd0,
    NP_DRAIN = 2'd1,
    NP_NPREQ = 2'd2,
    NP_DONE  = 2'd3
  } np_state_t;

  // Accept and drain on the same edge cancel out.
  function automatic logic [1:0] cnt_step(input logic [1:0] cnt,
                                          input logic push,
                                          input logic pop);
    logic [1:0] r;
    r = cnt;
    if (push && !pop) r = cnt + 2'd1;
    else if (pop && !push) r = cnt - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/io_post_ctl_pw_fifo_ctl.sv
// Occupancy and slot pointers for the two-entry posted-write buffer.
// Pushes into a full buffer and pops from an empty one are dropped.
module io_post_ctl_pw_fifo_ctl
  import io_post_ctl_pkg::*;
(
  input  logic       FCLK,
  input  logic       nRST,
  input  logic       push,
  input  logic       pop,
  output logic [1:0] cnt_next,
  output logic       wptr,
  output logic       rptr,
  output logic       full,
  output logic       empty
);

  logic [1:0] cnt;
  logic       do_push;
  logic       do_pop;

  assign full     = (cnt == PW_DEPTH);
  assign empty    = (cnt == 2'd0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign cnt_next = cnt_step(cnt, do_push, do_pop);

  always_ff @(posedge FCLK or negedge nRST) begin
    if (!nRST) begin
      cnt  <= 2'd0;
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (do_push) wptr <= ~wptr;
      if (do_pop)  rptr <= ~rptr;
    end
  end

endmodule

// File: rtl/io_post_ctl.sv
// IO posted-write controller: buffers CPU posted writes, drains them to the
// IO side and orders non-posted IO accesses behind all buffered writes.
module io_post_ctl
  import io_post_ctl_pkg::*;
(
  input  logic FCLK,
  input  logic nRST,
  input  logic BACT,
  input  logic BACTr,
  input  logic IOCS,
  input  logic IOPWCS,
  input  logic nWE,
  output logic IOPWReady,
  output logic IONPReady,
  output logic IOREQ,
  output logic IOWR,
  output logic IOPW,
  output logic PWLoad,
  output logic PWSlot,
  input  logic IOACK
);

  logic       cyc_start;
  logic       pw_cyc;
  logic       pw_start;
  logic       np_start;
  logic       pw_pend;
  logic       accept;
  logic       drain_start;
  logic       drain_done;
  logic       req_ok;
  logic [1:0] hold;
  logic [1:0] cnt_next;
  logic       wptr;
  logic       rptr_unused;
  logic       full;
  logic       empty;
  logic       np_wr;
  logic       np_abort;
  np_state_t  state;

  assign cyc_start   = BACT && !BACTr;
  assign pw_cyc      = IOPWCS && !nWE;
  assign pw_start    = cyc_start && pw_cyc;
  assign np_start    = cyc_start && IOCS && !pw_cyc;
  assign accept      = (pw_start || pw_pend) && !full;
  assign req_ok      = hold[1];
  assign drain_done  = IOREQ && IOPW && IOACK;
  assign drain_start = !empty && !IOREQ && (state != NP_NPREQ) && req_ok;

  io_post_ctl_pw_fifo_ctl u_fifo (
    .FCLK     (FCLK),
    .nRST     (nRST),
    .push     (accept),
    .pop      (drain_done),
    .cnt_next (cnt_next),
    .wptr     (wptr),
    .rptr     (rptr_unused),
    .full     (full),
    .empty    (empty)
  );

  // CPU side: buffer loading, stalled posted writes and the ready flag.
  // hold keeps requests off the IO side for two edges after reset release.
  always_ff @(posedge FCLK or negedge nRST) begin
    if (!nRST) begin
      pw_pend   <= 1'b0;
      PWLoad    <= 1'b0;
      PWSlot    <= 1'b0;
      IOPWReady <= 1'b1;
      hold      <= 2'b00;
    end else begin
      hold      <= {hold[0], 1'b1};
      PWLoad    <= accept;
      IOPWReady <= (cnt_next != PW_DEPTH);
      if (accept) begin
        PWSlot  <= wptr;
        pw_pend <= 1'b0;
      end else if (pw_start) begin
        pw_pend <= 1'b1;
      end
    end
  end

  // IO request arbitration and the non-posted FSM. Drains win whenever the
  // buffer is non-empty, so the NP request only goes out once it is empty.
  always_ff @(posedge FCLK or negedge nRST) begin
    if (!nRST) begin
      state     <= NP_IDLE;
      IOREQ     <= 1'b0;
      IOWR      <= 1'b0;
      IOPW      <= 1'b0;
      IONPReady <= 1'b0;
      np_wr     <= 1'b0;
      np_abort  <= 1'b0;
    end else begin
      if (IOREQ && IOACK) begin
        IOREQ <= 1'b0;
        IOWR  <= 1'b0;
        IOPW  <= 1'b0;
      end else if (drain_start) begin
        IOREQ <= 1'b1;
        IOWR  <= 1'b1;
        IOPW  <= 1'b1;
      end

      case (state)
        NP_IDLE: begin
          if (np_start) begin
            state <= NP_DRAIN;
            np_wr <= !nWE;
          end
        end
        NP_DRAIN: begin
          if (!BACT) begin
            state <= NP_IDLE;
          end else if (empty && !IOREQ && req_ok) begin
            state    <= NP_NPREQ;
            IOREQ    <= 1'b1;
            IOWR     <= np_wr;
            IOPW     <= 1'b0;
            np_abort <= 1'b0;
          end
        end
        NP_NPREQ: begin
          if (!BACT) np_abort <= 1'b1;
          // An aborted cycle still completes on the IO side but never signals ready.
          if (IOACK) begin
            state     <= (BACT && !np_abort) ? NP_DONE : NP_IDLE;
            IONPReady <= BACT && !np_abort;
          end
        end
        NP_DONE: begin
          if (!BACT) begin
            state     <= NP_IDLE;
            IONPReady <= 1'b0;
          end
        end
        default: state <= NP_IDLE;
      endcase
    end
  end

endmodule

// File: doc/io_post_ctl.md
IO_POST_CTL -- requirements
Module: io_post_ctl

Interface
REQ-001 SHALL have ports: FCLK in 1 system clock, all state changes on posedge; nRST in 1 async active-low reset.
REQ-002 SHALL have CPU-side inputs: BACT in 1 bus active; BACTr in 1 BACT registered on posedge FCLK; IOCS in 1 IO space selected; IOPWCS in 1 posted-write-capable space selected; nWE in 1 CPU write (low = write).
REQ-003 SHALL have CPU-side outputs: IOPWReady out 1 posted-write buffer not full; IONPReady out 1 non-posted IO access complete.
REQ-004 SHALL have IO-side ports: IOREQ out 1 IO transaction request; IOWR out 1 request is a write; IOPW out 1 request is a posted-buffer drain; PWLoad out 1 one-cycle strobe to latch CPU address/data into buffer slot; PWSlot out 1 slot written by PWLoad; IOACK in 1 one-cycle IO completion pulse.

Function
REQ-005 SHALL detect cycle start as BACT && !BACTr; SHALL classify at start: PW cycle = IOPWCS && !nWE; NP cycle = IOCS && !(IOPWCS && !nWE); otherwise ignore.
REQ-006 SHALL keep a 2-bit count PWCnt (0..2) of buffered posted writes, 1-bit write pointer WPtr and read pointer RPtr, both wrapping 1->0.
REQ-007 SHALL register IOPWReady = (next PWCnt < 2); high out of reset.
REQ-008 On PW cycle start with PWCnt<2, SHALL accept same edge: PWLoad=1 one cycle, PWSlot=WPtr, WPtr toggles, PWCnt+1.
REQ-009 On PW cycle start with PWCnt==2, SHALL set PWPend; SHALL accept (as REQ-008) on the first edge where registered PWCnt<2, then clear PWPend.
REQ-010 Drain: when PWCnt>0, no drain/NP request outstanding and NP FSM not in NPREQ, SHALL raise IOREQ=1, IOWR=1, IOPW=1, held until IOACK; on IOACK SHALL drop IOREQ next edge, toggle RPtr, PWCnt-1.
REQ-011 Accept and drain-complete on the same edge SHALL leave PWCnt unchanged; PWCnt SHALL never exceed 2 nor underflow.
REQ-012 NP FSM states: IDLE, DRAIN, NPREQ, DONE.
REQ-013 IDLE->DRAIN on NP cycle start; DRAIN->NPREQ when PWCnt==0 and no drain outstanding (writes are ordered before non-posted accesses).
REQ-014 NPREQ: IOREQ=1, IOWR=!nWE, IOPW=0 held until IOACK; ->DONE on IOACK.
REQ-015 DONE: IONPReady=1 registered, held until !BACT; ->IDLE when !BACT.
REQ-016 If BACT falls in DRAIN (aborted cycle), SHALL return to IDLE without issuing NP request; if BACT falls in NPREQ, SHALL complete request, then go to IDLE without asserting IONPReady.
REQ-017 Drain SHALL have priority over NP when both pending; only one IOREQ outstanding at a time.
REQ-018 IOACK while IOREQ low SHALL be ignored.

Reset
REQ-019 On nRST low, asynchronously: PWCnt=0, WPtr=RPtr=0, PWPend=0, FSM=IDLE, IOREQ=IOWR=IOPW=PWLoad=PWSlot=0, IONPReady=0, IOPWReady=1.
REQ-020 Reset mid-transaction SHALL discard buffered writes and outstanding request; no IOREQ for two edges after nRST release.

Structure
REQ-021 NP FSM state encodings and buffer depth (2) SHALL live in the shared cpld definitions include.
REQ-022 Sub-module pw_fifo_ctl (PWCnt, WPtr, RPtr, full/empty) is natural; FSM and request arbitration stay in io_post_ctl.

Verification
REQ-023 Two PW cycles from empty -> PWLoad slots 0,1; PWCnt=2; IOPWReady=0 after second accept.
REQ-024 Third PW cycle with PWCnt=2 -> IOPWReady low until first IOACK; accept one edge after PWCnt=1; PWSlot=0.
REQ-025 NP read with PWCnt=2 -> two drain requests (IOPW=1) complete first; then IOREQ, IOWR=0, IOPW=0; IONPReady=1 edge after IOACK, cleared edge after BACT low.
REQ-026 PW accept and drain IOACK on same edge with PWCnt=1 -> PWCnt stays 1, WPtr and RPtr both toggle.
REQ-027 nRST low during NPREQ with PWCnt=2 -> IOREQ=0, PWCnt=0, IOPWReady=1 immediately; stray IOACK ignored.
REQ-028 BACT drops while in DRAIN -> FSM IDLE, no NP IOREQ, IONPReady stays 0.
